// File: rtl/ctrl_pkg.sv
// Shared types and defaults for the sum-of-integers controller.
// The FSM state type and the default accumulator width live here so the top and datapath agree.
package ctrl_pkg;

  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/acc_datapath.sv
// Counter/adder datapath: cnt steps 1,2,3,... while acc accumulates it.
// last flags that the term currently in cnt is the final one (cnt == N).
module acc_datapath
  import ctrl_pkg::*;
#(
  parameter int N     = 10,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [ACC_W-1:0] acc,
  output logic             last
);

  logic [ACC_W-1:0] cnt;

  // clr primes the first term; en performs one add-and-advance step
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= ACC_W'(1);
    end else if (en) begin
      acc <= acc + cnt;
      cnt <= cnt + ACC_W'(1);
    end
  end

  assign last = (cnt == ACC_W'(N));

endmodule

// File: rtl/ctrl_top.sv
// Controller that sums 1..N into acc_o on a start request and then raises done_o.
// The FSM here sequences the acc_datapath through clear, N add steps, and a done hold.
module ctrl_top
  import ctrl_pkg::*;
#(
  parameter int N     = 10,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  output logic             done_o,
  output logic [ACC_W-1:0] acc_o
);

  state_t state;
  state_t state_next;
  logic   clr;
  logic   en;
  logic   last;

  // done_o is registered from the next state so it tracks DONE without decode glitches
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state  <= IDLE;
      done_o <= 1'b0;
    end else begin
      state  <= state_next;
      done_o <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    en         = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          clr        = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        en = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (!start_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  acc_datapath #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .en   (en),
    .acc  (acc_o),
    .last (last)
  );

endmodule

// File: tb/tb_ctrl_top.sv
// Randomized scoreboard bench for ctrl_top with N=10, N=1 and N=65535 instances.
// A cycle model built on the closed-form sum k*(k+1)/2 predicts acc/done; finished runs are queued and matched on done rise.
module tb_ctrl_top;
  import ctrl_pkg::*;

  localparam int NV [3] = '{10, 1, 65535};

  typedef struct {
    int          idx;
    logic [31:0] sum;
    longint      due;
  } res_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_v [3];
  logic        done_v  [3];
  logic [31:0] acc_v   [3];

  int     vectors = 0;
  int     errors  = 0;
  longint cyc     = 0;

  bit          m_busy    [3];
  bit          m_done    [3];
  longint      m_k       [3];
  logic [31:0] m_acc     [3];
  bit          prev_done [3];
  res_t        sb_q [$];

  always #5 clk = ~clk;

  ctrl_top #(.N(NV[0]), .ACC_W(32)) dut_n10 (
    .clk(clk), .rstn(rstn), .start_i(start_v[0]), .done_o(done_v[0]), .acc_o(acc_v[0])
  );
  ctrl_top #(.N(NV[1]), .ACC_W(32)) dut_n1 (
    .clk(clk), .rstn(rstn), .start_i(start_v[1]), .done_o(done_v[1]), .acc_o(acc_v[1])
  );
  ctrl_top #(.N(NV[2]), .ACC_W(32)) dut_big (
    .clk(clk), .rstn(rstn), .start_i(start_v[2]), .done_o(done_v[2]), .acc_o(acc_v[2])
  );

  function automatic logic [31:0] tri_sum(longint k);
    return 32'((k * (k + 1)) / 2);
  endfunction

  task automatic check_output(string name, int idx, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] at cycle %0d: got %0d expected %0d", name, idx, cyc, act, exp);
    end
  endtask

  // Reference model: after k run edges the sum is k*(k+1)/2; a start in idle queues the final result
  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_k[i]    = 0;
        m_acc[i]  = '0;
      end
      sb_q.delete();
    end else begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (m_busy[i]) begin
          m_k[i]++;
          m_acc[i] = tri_sum(m_k[i]);
          if (m_k[i] == longint'(NV[i])) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end else if (m_done[i]) begin
          if (!start_v[i]) m_done[i] = 1'b0;
        end else if (start_v[i]) begin
          m_busy[i] = 1'b1;
          m_k[i]    = 0;
          m_acc[i]  = '0;
          sb_q.push_back('{idx: i, sum: tri_sum(longint'(NV[i])), due: cyc + longint'(NV[i])});
        end
      end
    end
  end

  // Monitor: per-cycle acc/done tracking plus scoreboard pop on every done rise
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check_output("done", i, {31'b0, done_v[i]}, {31'b0, m_done[i]});
      check_output("acc", i, acc_v[i], m_acc[i]);
      if (done_v[i] && !prev_done[i]) begin
        int hit;
        hit = -1;
        for (int j = 0; j < sb_q.size(); j++)
          if (hit < 0 && sb_q[j].idx == i) hit = j;
        if (hit < 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected_done[%0d] at cycle %0d: got done=1 expected no pending run", i, cyc);
        end else begin
          check_output("result", i, acc_v[i], sb_q[hit].sum);
          check_output("latency", i, 32'(cyc), 32'(sb_q[hit].due));
          sb_q.delete(hit);
        end
      end
      prev_done[i] = done_v[i];
    end
  end

  task automatic apply_stimulus(int idx, logic val);
    @(negedge clk);
    start_v[idx] = val;
  endtask

  task automatic wait_done(int idx, int budget);
    int n;
    n = 0;
    while (!done_v[idx] && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!done_v[idx]) begin
      errors++;
      $display("[TB] FAIL done_timeout[%0d]: got done=0 after %0d cycles expected done=1", idx, budget);
    end
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 3; i++) begin
      check_output("rst_acc", i, acc_v[i], 32'd0);
      check_output("rst_done", i, {31'b0, done_v[i]}, 32'd0);
    end
  endtask

  initial begin
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    repeat (6) @(negedge clk);

    // basic run, hold in DONE, then restart after a one-cycle drop
    apply_stimulus(0, 1'b1);
    wait_done(0, 40);
    repeat (3) @(negedge clk);
    start_v[0] = 1'b0;
    apply_stimulus(0, 1'b1);
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);

    // random start activity on the small instances, including drops during RUN
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start_v[0] = ($urandom_range(0, 3) != 0);
      start_v[1] = ($urandom_range(0, 1) != 0);
    end
    apply_stimulus(0, 1'b0);
    start_v[1] = 1'b0;
    repeat (15) @(negedge clk);

    // asynchronous reset in the middle of a run, released with start still high
    apply_stimulus(0, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    rstn = 1'b0;
    wait_done(0, 40);
    apply_stimulus(0, 1'b0);
    repeat (3) @(negedge clk);

    apply_stimulus(1, 1'b1);
    wait_done(1, 10);
    repeat (2) @(negedge clk);
    start_v[1] = 1'b0;
    repeat (3) @(negedge clk);

    apply_stimulus(2, 1'b1);
    wait_done(2, 70000);
    repeat (2) @(negedge clk);
    start_v[2] = 1'b0;
    repeat (3) @(negedge clk);

    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_results: got %0d unmatched runs expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
